// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end of the 8-bit processor. It reads 1- or 2-byte instructions from memory
// and presents the decoded fields to execute through a valid/ready handshake.
module instr_fetch_decode #(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [3:0]    dec_opcode,
  output logic [1:0]    dec_rd,
  output logic [1:0]    dec_rs,
  output logic [DW-1:0] dec_imm,
  output logic          dec_len2,
  output logic [AW-1:0] dec_pc
);

  localparam logic [2:0] OP_REQ   = 3'd0;
  localparam logic [2:0] OP_WAIT  = 3'd1;
  localparam logic [2:0] IMM_REQ  = 3'd2;
  localparam logic [2:0] IMM_WAIT = 3'd3;
  localparam logic [2:0] OUT      = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] decPc_q, decPc_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    rs_q, rs_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          len2_q, len2_d;

  // iread, iwrite, buc, biz and bio carry a second byte.
  function automatic logic isTwoByte(input logic [3:0] op);
    return (op == 4'b1001) || (op == 4'b1011) || (op == 4'b1101) ||
           (op == 4'b1110) || (op == 4'b1111);
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    decPc_d  = decPc_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    imm_d    = imm_q;
    len2_d   = len2_q;
    if (redirect) begin
      // A redirect wins everywhere; any byte returning this cycle is ignored.
      pc_d    = redirect_addr;
      state_d = OP_REQ;
    end else begin
      case (state_q)
        OP_REQ: begin
          decPc_d = pc_q;
          state_d = OP_WAIT;
        end
        OP_WAIT: begin
          opcode_d = mem_rdata[7:4];
          rd_d     = mem_rdata[3:2];
          rs_d     = mem_rdata[1:0];
          pc_d     = pc_q + AW'(1);
          if (isTwoByte(mem_rdata[7:4])) begin
            len2_d  = 1'b1;
            state_d = IMM_REQ;
          end else begin
            len2_d  = 1'b0;
            imm_d   = '0;
            state_d = OUT;
          end
        end
        IMM_REQ:  state_d = IMM_WAIT;
        IMM_WAIT: begin
          imm_d   = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = OUT;
        end
        OUT: begin
          if (dec_ready) state_d = OP_REQ;
        end
        default: state_d = OP_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OP_REQ;
      pc_q     <= RESET_PC;
      decPc_q  <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_q    <= '0;
      len2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      decPc_q  <= decPc_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      imm_q    <= imm_d;
      len2_q   <= len2_d;
    end
  end

  // The strobe is masked while reset is held so no read starts from the reset state.
  assign mem_rd     = !rst && ((state_q == OP_REQ) || (state_q == IMM_REQ));
  assign mem_addr   = mem_rd ? pc_q : '0;
  assign dec_valid  = (state_q == OUT);
  assign dec_opcode = opcode_q;
  assign dec_rd     = rd_q;
  assign dec_rs     = rs_q;
  assign dec_imm    = imm_q;
  assign dec_len2   = len2_q;
  assign dec_pc     = decPc_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a byte-wide memory model answers reads one cycle later,
// and each step compares outputs against hand-computed values.
module tb_instr_fetch_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       memRd;
  logic [7:0] memAddr;
  logic [7:0] memRdata = 8'h00;
  logic       redirect;
  logic [7:0] redirectAddr;
  logic       decValid;
  logic       decReady;
  logic [3:0] decOpcode;
  logic [1:0] decRd;
  logic [1:0] decRs;
  logic [7:0] decImm;
  logic       decLen2;
  logic [7:0] decPc;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  instr_fetch_decode #(.AW(8), .DW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .mem_rd(memRd), .mem_addr(memAddr), .mem_rdata(memRdata),
    .redirect(redirect), .redirect_addr(redirectAddr),
    .dec_valid(decValid), .dec_ready(decReady),
    .dec_opcode(decOpcode), .dec_rd(decRd), .dec_rs(decRs),
    .dec_imm(decImm), .dec_len2(decLen2), .dec_pc(decPc)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (memRd) memRdata <= mem[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkFetch(input string tag, input logic [7:0] addr);
    checkOutput({tag, "_rd"}, 32'(memRd), 32'd1);
    checkOutput({tag, "_addr"}, 32'(memAddr), 32'(addr));
  endtask

  task automatic checkDecode(input string tag, input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [7:0] imm, input logic len2,
                             input logic [7:0] pc);
    checkOutput({tag, "_valid"}, 32'(decValid), 32'd1);
    checkOutput({tag, "_op"}, 32'(decOpcode), 32'(op));
    checkOutput({tag, "_rd"}, 32'(decRd), 32'(rd));
    checkOutput({tag, "_rs"}, 32'(decRs), 32'(rs));
    checkOutput({tag, "_imm"}, 32'(decImm), 32'(imm));
    checkOutput({tag, "_len2"}, 32'(decLen2), 32'(len2));
    checkOutput({tag, "_pc"}, 32'(decPc), 32'(pc));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_memrd"}, 32'(memRd), 32'd0);
    checkOutput({tag, "_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_valid"}, 32'(decValid), 32'd0);
    checkOutput({tag, "_fields"}, {decOpcode, decRd, decRs, decImm, decLen2, decPc}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirectAddr = 8'h00;
    decReady = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]   = 8'h90;
    mem[1]   = 8'h1E;
    mem[2]   = 8'h25;
    mem[4]   = 8'hF0;
    mem[5]   = 8'h09;
    mem[6]   = 8'h01;
    mem[9]   = 8'hB2;
    mem[10]  = 8'h55;
    mem[255] = 8'hD0;

    applyStimulus(2);
    checkResetState("reset");

    // iread R0,R0 with imm 30 at address 0
    rst = 1'b0;
    decReady = 1'b1;
    #1;
    checkFetch("iread_op", 8'h00);
    applyStimulus(1);
    checkOutput("iread_wait_rd", 32'(memRd), 32'd0);
    applyStimulus(1);
    checkFetch("iread_imm", 8'h01);
    applyStimulus(1);
    checkOutput("iread_early_valid", 32'(decValid), 32'd0);
    applyStimulus(1);
    checkDecode("iread", 4'h9, 2'd0, 2'd0, 8'd30, 1'b1, 8'h00);

    // 1-byte instruction at 2, held for five cycles
    applyStimulus(1);
    checkFetch("hold_op", 8'h02);
    decReady = 1'b0;
    applyStimulus(2);
    for (int k = 0; k < 5; k++) begin
      checkDecode("hold", 4'h2, 2'd1, 2'd1, 8'h00, 1'b0, 8'h02);
      checkOutput("hold_memrd", 32'(memRd), 32'd0);
      if (k < 4) applyStimulus(1);
    end
    decReady = 1'b1;
    applyStimulus(1);
    checkFetch("after_hold", 8'h03);

    // Redirect during OP_REQ to iadd R0,R1 at 6
    redirect = 1'b1;
    redirectAddr = 8'h06;
    applyStimulus(1);
    redirect = 1'b0;
    checkFetch("redir6", 8'h06);
    applyStimulus(2);
    checkDecode("iadd", 4'h0, 2'd0, 2'd1, 8'h00, 1'b0, 8'h06);
    applyStimulus(1);
    checkFetch("next7", 8'h07);

    // bio at 4, taken branch to 9 on the handshake cycle
    redirect = 1'b1;
    redirectAddr = 8'h04;
    applyStimulus(1);
    redirect = 1'b0;
    checkFetch("redir4", 8'h04);
    applyStimulus(2);
    checkFetch("bio_imm", 8'h05);
    applyStimulus(2);
    checkDecode("bio", 4'hF, 2'd0, 2'd0, 8'h09, 1'b1, 8'h04);
    redirect = 1'b1;
    redirectAddr = 8'h09;
    applyStimulus(1);
    redirect = 1'b0;
    checkOutput("branch_valid", 32'(decValid), 32'd0);
    checkFetch("branch9", 8'h09);

    // iwrite at 9 flushed during IMM_WAIT, redirect to 255
    applyStimulus(2);
    checkFetch("iwrite_imm", 8'h0A);
    applyStimulus(1);
    redirect = 1'b1;
    redirectAddr = 8'hFF;
    mem[0] = 8'h04;
    applyStimulus(1);
    redirect = 1'b0;
    checkOutput("flush_valid", 32'(decValid), 32'd0);
    checkFetch("redir255", 8'hFF);

    // buc at 255 wraps for its immediate
    applyStimulus(2);
    checkFetch("wrap_imm", 8'h00);
    applyStimulus(2);
    checkDecode("buc", 4'hD, 2'd0, 2'd0, 8'h04, 1'b1, 8'hFF);
    applyStimulus(1);
    checkFetch("wrap_next", 8'h01);

    // Held instruction dropped by redirect without handshake
    decReady = 1'b0;
    applyStimulus(2);
    checkDecode("drop", 4'h1, 2'd3, 2'd2, 8'h00, 1'b0, 8'h01);
    redirect = 1'b1;
    redirectAddr = 8'h06;
    applyStimulus(1);
    redirect = 1'b0;
    checkOutput("drop_valid", 32'(decValid), 32'd0);
    checkFetch("drop_redir", 8'h06);

    // Reset in the middle of a fetch
    applyStimulus(1);
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    applyStimulus(1);
    rst = 1'b0;
    #1;
    checkFetch("post_reset", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Front end of the 8-bit processor. It fetches instruction bytes from the unified program/data memory at the program counter and assembles 1-byte and 2-byte instructions. It splits each instruction into opcode, Rd, Rs and immediate/address fields, then presents them to the execute stage through a valid/ready handshake. Execute redirects the fetch PC on taken branches (buc/biz/bio).

Parameters:
AW, 8, memory address width and PC width.
DW, 8, memory data / instruction byte width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
mem_rd  output  1  memory read strobe, one cycle per byte.
mem_addr  output  AW  memory read address.
mem_rdata  input  DW  read data, valid the cycle after mem_rd.
redirect  input  1  taken branch from execute; flush and reload PC.
redirect_addr  input  AW  new PC when redirect=1.
dec_valid  output  1  decoded instruction available.
dec_ready  input  1  execute accepts the instruction.
dec_opcode  output  4  instruction byte [7:4].
dec_rd  output  2  instruction byte [3:2].
dec_rs  output  2  instruction byte [1:0].
dec_imm  output  DW  second byte; 0 for 1-byte instructions.
dec_len2  output  1  1 if the instruction is 2 bytes.
dec_pc  output  AW  address of the opcode byte.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC, state=OP_REQ.
  - mem_rd=0, mem_addr=0, dec_valid=0, all dec_* fields=0.
- 2-byte opcodes: iread 1001, iwrite 1011, buc 1101, biz 1110, bio 1111. All other opcodes are 1 byte.
- FSM states: OP_REQ, OP_WAIT, IMM_REQ, IMM_WAIT, OUT.
  - OP_REQ: mem_rd=1, mem_addr=PC, latch dec_pc=PC. Go to OP_WAIT.
  - OP_WAIT: capture mem_rdata into opcode/rd/rs, PC=PC+1. Go to IMM_REQ if the opcode is 2-byte; otherwise set imm=0 and go to OUT.
  - IMM_REQ: mem_rd=1, mem_addr=PC. Go to IMM_WAIT.
  - IMM_WAIT: capture mem_rdata into imm, PC=PC+1. Go to OUT.
  - OUT: dec_valid=1, fields stable. On dec_ready=1, go to OP_REQ with dec_valid=0 next cycle. Otherwise hold.
- mem_rd is 0 in all states except OP_REQ and IMM_REQ.
- Latency:
  - 1-byte instruction: dec_valid 2 cycles after OP_REQ.
  - 2-byte instruction: dec_valid 4 cycles after OP_REQ.
  - Back-to-back throughput is one instruction per 3 cycles (1-byte) or 5 cycles (2-byte) with dec_ready held high.
- PC arithmetic is modulo 2^AW. A 2-byte instruction at 255 takes its immediate from address 0, and the next PC is 1.
- Redirect (sampled at clk edge, any state):
  - PC=redirect_addr, state=OP_REQ, dec_valid=0 next cycle.
  - Any partially fetched instruction is discarded, including a read data byte arriving that cycle.
- redirect=1 together with dec_valid&dec_ready: the handshake completes (execute owns that instruction) and the redirect is applied. This is the normal taken-branch case.
- redirect=1 with dec_valid=1, dec_ready=0: the held instruction is dropped.
- Opcodes inop, regd and regid get no special handling; they decode as ordinary 1-byte instructions.
- rst asserted mid-fetch: immediate return to reset values, with no memory strobe completing.

Test Plan:
- Reset, mem[0]=0x90, mem[1]=30, dec_ready=1 -> mem_rd at addr 0 then 1; dec_valid with opcode=9, rd=0, rs=0, imm=30, len2=1, pc=0, 4 cycles after the first OP_REQ.
- mem[6]=0x01 (iadd R0,R1), start via redirect_addr=6 -> opcode=0, rd=0, rs=1, imm=0, len2=0, pc=6; next fetch at addr 7.
- Program mem[4]=0xF0, mem[5]=9 (bio), assert redirect with redirect_addr=9 on the handshake cycle -> next mem_addr=9, pc=9, no fetch of addr 6.
- Hold dec_ready=0 for 5 cycles in OUT -> dec_valid and all fields stable, mem_rd=0, PC unchanged; release -> next fetch at expected PC.
- Redirect asserted during IMM_WAIT of a 2-byte instruction -> no dec_valid for it; next mem_addr=redirect_addr.
- Redirect to 255 with mem[255]=0xD0 (buc), mem[0]=0x04 -> imm=4, len2=1, pc=255; next fetch address 1.
